bufx2_asap7_75t_r: RTL and testbench
====================================

# bufx2_asap7_75t_r

Instrumented behavioural model of the ASAP7 BUFx2 standard-cell buffer. It is used wherever a cell is placed in the xilinx2asic wrappers, for example on the PLL clock, reset and data outputs. The A→Y path is a pure zero-delay combinational buffer. A clocked activity monitor counts input transitions and reports per-window toggle counts for power and activity estimation.

## Interface
Parameters:
- CNT_W, 16, width of all counters (≥ 2)
- WINDOW, 256, measurement window length in CLK cycles (≥ 2)

Ports:
- Clocking: one clock; reset is synchronous and active-low.
- CLK  in  1  monitor clock, rising edge
- RST_N  in  1  synchronous active-low reset
- A  in  1  buffer input
- Y  out  1  buffer output, equal to A
- CLR  in  1  synchronous clear of statistics, active-high
- A_Q  out  1  A registered on CLK
- RISE_CNT  out  CNT_W  rising transitions since reset/CLR, saturating
- FALL_CNT  out  CNT_W  falling transitions since reset/CLR, saturating
- WIN_TOGGLES  out  CNT_W  total transitions in last completed window, saturating
- WIN_VALID  out  1  one-cycle pulse when WIN_TOGGLES updates

## Operation
- Y = A at all times, combinationally.
  - Y is independent of CLK, RST_N and CLR.
  - Y is never registered or gated.
- A_Q samples A every CLK edge.
- A `primed` flag is cleared by reset and set on the first post-reset edge.
  - Edge detection is suppressed while `primed`=0, so the initial level of A never counts as an edge.
- At each edge with `primed`=1:
  - rise = A & ~A_Q
  - fall = ~A & A_Q
  - toggle = rise | fall
- RISE_CNT increments on rise and FALL_CNT increments on fall.
  - Both stick at 2^CNT_W−1 and never wrap.
- Window counter `wcnt` runs 0..WINDOW−1 and wraps to 0.
  - Accumulator `wacc` adds toggle each cycle and saturates.
  - On the cycle where `wcnt`=WINDOW−1: WIN_TOGGLES ← sat(`wacc`+toggle), WIN_VALID ← 1, `wacc` ← 0.
  - On all other cycles WIN_VALID ← 0.
- CLR=1 for a cycle:
  - RISE_CNT, FALL_CNT, `wcnt`, `wacc`, WIN_TOGGLES and WIN_VALID all ← 0.
  - Any edge sampled in that cycle is discarded.
  - A_Q and `primed` still update normally.
- Priority: RST_N low > CLR > normal counting.

## Timing
- Reset values, after a CLK edge with RST_N=0: A_Q=0, `primed`=0, all counters 0, WIN_TOGGLES=0, WIN_VALID=0. Y keeps following A.
- A change settling before edge k:
  - A_Q reflects the change after edge k.
  - RISE_CNT/FALL_CNT reflect it after edge k: one-cycle latency, with no extra pipeline stage.
- An A pulse that starts and ends between two CLK edges is invisible to the monitor; there is no asynchronous capture.
- First window after reset or CLR: WIN_VALID pulses after edge WINDOW (edges counted from 1 after the release).
- Later windows: WIN_VALID pulses every WINDOW edges.
- Saturation is evaluated per counter. A saturated RISE_CNT does not stop FALL_CNT or the window logic.
- Reset asserted mid-window discards the partial window; no WIN_VALID is issued for it.

## Structure
- Shared package `bufx2_mon_pkg`: default CNT_W and WINDOW constants, plus a `sat_inc` function (increment, capped at all-ones).
- Sub-module `bufx2_sat_counter` (CNT_W, sync clear, increment enable, saturating), instantiated three times: RISE_CNT, FALL_CNT and `wacc`.
- Top level holds the combinational Y assign, the A_Q/`primed` registers, edge detect, `wcnt` and the WIN_TOGGLES register.

## Test plan
- Reset sequence: hold RST_N=0 for 3 cycles with A=1, then release with A=1 held for 10 cycles.
  - Required: Y=1 throughout; RISE_CNT=0 and FALL_CNT=0; A_Q=1 after the first edge following release.
- Combinational path: toggle A with CLK stopped and RST_N=0.
  - Required: Y tracks A with zero delay every time.
- Counting: set A=0, then 5 full pulses of 1 cycle high / 1 cycle low.
  - Required: RISE_CNT=5 and FALL_CNT=5 one cycle after the last fall.
- Window: WINDOW=8, A toggles every cycle from release.
  - Required: WIN_VALID pulses after edges 8, 16, 24 and so on.
  - WIN_TOGGLES=7 for the first window (the priming edge is excluded) and 8 for every later window.
- Saturation and clear: CNT_W=2, 6 rising edges.
  - Required: RISE_CNT sticks at 3.
  - Then CLR=1 in the same cycle as a rise: RISE_CNT=0 afterwards, and the next rise gives RISE_CNT=1.

Source files
------------

// File: rtl/bufx2_mon_pkg.sv
// Shared defaults and saturating-increment helper for the BUFx2 activity monitor.
package bufx2_mon_pkg;

  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_WINDOW = 256;

  // Increment v, capped at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/bufx2_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
module bufx2_sat_counter
  import bufx2_mon_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/bufx2_asap7_75t_r.sv
// BUFx2 behavioural buffer (Y = A) with a clocked edge/toggle activity monitor.
module bufx2_asap7_75t_r
  import bufx2_mon_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned WINDOW = DEF_WINDOW
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A,
  output logic             Y,
  input  logic             CLR,
  output logic             A_Q,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] FALL_CNT,
  output logic [CNT_W-1:0] WIN_TOGGLES,
  output logic             WIN_VALID
);

  localparam int unsigned WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WCNT_W-1:0] WLAST = WCNT_W'(WINDOW - 1);

  logic              a_q, a_d;
  logic              primed_q, primed_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  win_tog_q, win_tog_d;
  logic              win_vld_q, win_vld_d;
  logic              rise, fall, toggle, win_end, wacc_clr;
  logic [CNT_W-1:0]  wacc;

  // The cell itself: a pure combinational buffer, untouched by the monitor.
  assign Y = A;

  always_comb begin
    a_d       = A;
    primed_d  = 1'b1;
    rise      = primed_q & A & ~a_q;
    fall      = primed_q & ~A & a_q;
    toggle    = rise | fall;
    win_end   = (wcnt_q == WLAST);
    wcnt_d    = win_end ? '0 : wcnt_q + WCNT_W'(1);
    win_tog_d = win_tog_q;
    win_vld_d = 1'b0;
    wacc_clr  = CLR | win_end;
    if (CLR) begin
      wcnt_d    = '0;
      win_tog_d = '0;
    end else if (win_end) begin
      win_tog_d = toggle ? CNT_W'(sat_inc(64'(wacc), CNT_W)) : wacc;
      win_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_q       <= 1'b0;
      primed_q  <= 1'b0;
      wcnt_q    <= '0;
      win_tog_q <= '0;
      win_vld_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      primed_q  <= primed_d;
      wcnt_q    <= wcnt_d;
      win_tog_q <= win_tog_d;
      win_vld_q <= win_vld_d;
    end
  end

  bufx2_sat_counter #(.CNT_W(CNT_W)) u_rise (
    .clk(CLK), .rst_n(RST_N), .clr(CLR), .inc(rise), .cnt(RISE_CNT)
  );

  bufx2_sat_counter #(.CNT_W(CNT_W)) u_fall (
    .clk(CLK), .rst_n(RST_N), .clr(CLR), .inc(fall), .cnt(FALL_CNT)
  );

  // Window accumulator is emptied on clear and at every window boundary.
  bufx2_sat_counter #(.CNT_W(CNT_W)) u_wacc (
    .clk(CLK), .rst_n(RST_N), .clr(wacc_clr), .inc(toggle), .cnt(wacc)
  );

  assign A_Q         = a_q;
  assign WIN_TOGGLES = win_tog_q;
  assign WIN_VALID   = win_vld_q;

endmodule

// File: tb/tb_bufx2_asap7_75t_r.sv
// Bench for bufx2_asap7_75t_r: two configurations share stimulus, checked by vectors and a model.
module tb_bufx2_asap7_75t_r;

  logic CLK = 1'b0;
  logic clk_en = 1'b0;
  logic RST_N, A, CLR;

  logic       ya, aqa, vlda;
  logic [7:0] risea, falla, toga;
  logic       ys, aqs, vlds;
  logic [1:0] rises, falls, togs;

  bufx2_asap7_75t_r #(.CNT_W(8), .WINDOW(8)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .A(A), .Y(ya), .CLR(CLR), .A_Q(aqa),
    .RISE_CNT(risea), .FALL_CNT(falla), .WIN_TOGGLES(toga), .WIN_VALID(vlda)
  );

  bufx2_asap7_75t_r #(.CNT_W(2), .WINDOW(4)) dut_s (
    .CLK(CLK), .RST_N(RST_N), .A(A), .Y(ys), .CLR(CLR), .A_Q(aqs),
    .RISE_CNT(rises), .FALL_CNT(falls), .WIN_TOGGLES(togs), .WIN_VALID(vlds)
  );

  initial forever begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = dut_a (limit 255, window 8), index 1 = dut_s (limit 3, window 4)
  int m_max[2] = '{255, 3};
  int m_win[2] = '{8, 4};
  bit m_aq, m_primed;
  int m_rise[2], m_fall[2], m_edges[2], m_acc[2], m_wtog[2];
  bit m_wvld[2];

  function automatic int min2(int x, int y);
    return (x < y) ? x : y;
  endfunction

  task automatic model_edge(input bit a, input bit clr, input bit rstn);
    bit r, f;
    if (!rstn) begin
      m_aq = 0; m_primed = 0;
      for (int i = 0; i < 2; i++) begin
        m_rise[i] = 0; m_fall[i] = 0; m_edges[i] = 0; m_acc[i] = 0; m_wtog[i] = 0; m_wvld[i] = 0;
      end
      return;
    end
    r = m_primed && a && !m_aq;
    f = m_primed && !a && m_aq;
    m_aq = a;
    m_primed = 1;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_rise[i] = 0; m_fall[i] = 0; m_edges[i] = 0; m_acc[i] = 0; m_wtog[i] = 0; m_wvld[i] = 0;
      end else begin
        m_rise[i] = min2(m_rise[i] + int'(r), m_max[i]);
        m_fall[i] = min2(m_fall[i] + int'(f), m_max[i]);
        m_edges[i]++;
        if (m_edges[i] == m_win[i]) begin
          m_wtog[i] = min2(m_acc[i] + int'(r | f), m_max[i]);
          m_wvld[i] = 1;
          m_acc[i] = 0;
          m_edges[i] = 0;
        end else begin
          m_wvld[i] = 0;
          m_acc[i] = min2(m_acc[i] + int'(r | f), m_max[i]);
        end
      end
    end
  endtask

  task automatic model_check();
    chk("y_a", 32'(ya), 32'(A));
    chk("y_s", 32'(ys), 32'(A));
    chk("aq_a", 32'(aqa), 32'(m_aq));
    chk("aq_s", 32'(aqs), 32'(m_aq));
    chk("rise_a", 32'(risea), m_rise[0]);
    chk("fall_a", 32'(falla), m_fall[0]);
    chk("wtog_a", 32'(toga), m_wtog[0]);
    chk("wvld_a", 32'(vlda), 32'(m_wvld[0]));
    chk("rise_s", 32'(rises), m_rise[1]);
    chk("fall_s", 32'(falls), m_fall[1]);
    chk("wtog_s", 32'(togs), m_wtog[1]);
    chk("wvld_s", 32'(vlds), 32'(m_wvld[1]));
  endtask

  // One clock: drive inputs away from the edge, advance the model, sample 1 time unit later.
  task automatic step(input bit a, input bit clr, input bit rstn);
    A = a; CLR = clr; RST_N = rstn;
    @(posedge CLK);
    model_edge(a, clr, rstn);
    #1;
    model_check();
  endtask

  typedef struct {
    bit a, clr, rstn;
    bit exp_aq;
    int exp_rise, exp_fall;
  } vec_t;

  vec_t vecs[$];

  task automatic vec(input bit a, input bit clr, input bit rstn, input bit aq, input int rs, input int fl);
    vec_t v;
    v.a = a; v.clr = clr; v.rstn = rstn; v.exp_aq = aq; v.exp_rise = rs; v.exp_fall = fl;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset 3 cycles with A=1, release 10 cycles at A=1, clear with A=0, then 5 pulses on dut_a.
    for (int i = 0; i < 3; i++) vec(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) vec(1, 0, 1, 1, 0, 0);
    vec(0, 1, 1, 0, 0, 0);
    vec(1, 0, 1, 1, 1, 0); vec(0, 0, 1, 0, 1, 1);
    vec(1, 0, 1, 1, 2, 1); vec(0, 0, 1, 0, 2, 2);
    vec(1, 0, 1, 1, 3, 2); vec(0, 0, 1, 0, 3, 3);
    vec(1, 0, 1, 1, 4, 3); vec(0, 0, 1, 0, 4, 4);
    vec(1, 0, 1, 1, 5, 4); vec(0, 0, 1, 0, 5, 5);

    // Combinational path with the clock stopped and reset held.
    RST_N = 0; CLR = 0; A = 0;
    for (int i = 0; i < 6; i++) begin
      A = ~A;
      #1;
      chk("comb_y_a", 32'(ya), 32'(A));
      chk("comb_y_s", 32'(ys), 32'(A));
    end

    clk_en = 1;
    @(negedge CLK);
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].clr, vecs[i].rstn);
      chk("vec_y", 32'(ya), 32'(vecs[i].a));
      chk("vec_aq", 32'(aqa), 32'(vecs[i].exp_aq));
      chk("vec_rise", 32'(risea), vecs[i].exp_rise);
      chk("vec_fall", 32'(falla), vecs[i].exp_fall);
    end

    // Window: reset, then toggle every cycle from release; dut_a pulses at edges 8,16,24.
    step(0, 0, 0);
    for (int e = 1; e <= 24; e++) begin
      step(bit'(e & 1), 0, 1);
      chk("win_vld", 32'(vlda), 32'((e % 8) == 0));
      if (e == 8) chk("win_first", 32'(toga), 7);
      if (e == 16 || e == 24) chk("win_later", 32'(toga), 8);
      if (e % 4 == 0) chk("win_s_sat", 32'(togs), 3);
    end

    // Saturation on the 2-bit instance, then clear coinciding with a rise.
    step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1);
      step(0, 0, 1);
    end
    chk("sat_rise", 32'(rises), 3);
    chk("sat_fall", 32'(falls), 3);
    step(1, 1, 1);
    chk("clr_rise", 32'(rises), 0);
    step(0, 0, 1);
    step(1, 0, 1);
    chk("post_clr_rise", 32'(rises), 1);

    // Reset mid-window: no pulse for the abandoned partial window.
    for (int i = 0; i < 5; i++) step(bit'(i & 1), 0, 1);
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(bit'(i & 1), 0, 1);
      chk("midrst_no_vld", 32'(vlda), 0);
    end

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 2000; i++) begin
      bit ra, rc, rr;
      ra = bit'($urandom_range(0, 2) != 0) ^ m_aq;
      rc = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 299) != 0);
      step(ra, rc, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
